// File: rtl/mnist_pkg.sv
// Shared types and default configuration for the MNIST MLP layer sequencer.
package mnist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_L_START  = 3'd1,
        ST_L_WAIT   = 3'd2,
        ST_AM_RD    = 3'd3,
        ST_AM_DRAIN = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERR      = 3'd6
    } state_e;

    typedef struct packed {
        logic [15:0] in_words;
        logic [7:0]  neurons;
    } layer_cfg_t;

    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 32;

    typedef logic signed [SCORE_W-1:0] score_t;

    localparam int L1_IN_WORDS_C = 196;
    localparam int L1_NEURONS_C  = 60;
    localparam int L2_IN_WORDS_C = 60;
    localparam int L2_NEURONS_C  = 30;
    localparam int L3_IN_WORDS_C = 30;
    localparam int L3_NEURONS_C  = NUM_CLASSES;

    localparam layer_cfg_t L1_CFG = '{in_words: 16'd196, neurons: 8'd60};
    localparam layer_cfg_t L2_CFG = '{in_words: 16'd60,  neurons: 8'd30};
    localparam layer_cfg_t L3_CFG = '{in_words: 16'd30,  neurons: 8'd10};

    function automatic layer_cfg_t make_cfg(input int in_words, input int neurons);
        layer_cfg_t cfg;
        cfg.in_words = 16'(in_words);
        cfg.neurons  = 8'(neurons);
        return cfg;
    endfunction

endpackage

// File: rtl/mnist_layer_sequencer_score_argmax.sv
// Streaming signed argmax; outputs already include the sample presented this cycle.
module score_argmax #(
    parameter int W  = 32,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          valid,
    input  logic [W-1:0]  data,
    input  logic [IW-1:0] index,
    output logic [IW-1:0] best_idx,
    output logic [W-1:0]  best_val
);

    logic [IW-1:0] best_idx_q;
    logic [IW-1:0] best_idx_d;
    logic [W-1:0]  best_val_q;
    logic [W-1:0]  best_val_d;
    logic          take_s;

    // Strictly-greater update keeps the earliest index on ties
    always_comb begin
        take_s     = 1'b0;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        if (valid) begin
            take_s = start || ($signed(data) > $signed(best_val_q));
        end else begin
            take_s = 1'b0;
        end
        if (take_s) begin
            best_idx_d = index;
            best_val_d = data;
        end else begin
            best_idx_d = best_idx_q;
            best_val_d = best_val_q;
        end
    end

    // Running maximum storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_idx_q <= '0;
            best_val_q <= '0;
        end else begin
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
        end
    end

    assign best_idx = best_idx_d;
    assign best_val = best_val_d;

endmodule

// File: rtl/mnist_layer_sequencer.sv
// Top-level controller: runs the shared MAC through three layers, then argmaxes the scores.
module mnist_layer_sequencer
    import mnist_pkg::*;
#(
    parameter int L1_IN_WORDS    = L1_IN_WORDS_C,
    parameter int L1_NEURONS     = L1_NEURONS_C,
    parameter int L2_IN_WORDS    = L2_IN_WORDS_C,
    parameter int L2_NEURONS     = L2_NEURONS_C,
    parameter int L3_IN_WORDS    = L3_IN_WORDS_C,
    parameter int L3_NEURONS     = L3_NEURONS_C,
    parameter int SCORE_WIDTH    = SCORE_W,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_run,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic                   o_layer_start,
    output logic [1:0]             o_layer_sel,
    output logic [15:0]            o_in_words,
    output logic [7:0]             o_neurons,
    input  logic                   i_layer_done,
    output logic                   o_score_rd,
    output logic [3:0]             o_score_addr,
    input  logic [SCORE_WIDTH-1:0] i_score_data,
    output logic [3:0]             mnist_class
);

    localparam layer_cfg_t CFG_L1 = make_cfg(L1_IN_WORDS, L1_NEURONS);
    localparam layer_cfg_t CFG_L2 = make_cfg(L2_IN_WORDS, L2_NEURONS);
    localparam layer_cfg_t CFG_L3 = make_cfg(L3_IN_WORDS, L3_NEURONS);
    localparam logic [3:0]  LAST_ADDR = 4'(L3_NEURONS - 1);
    localparam bit          WD_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] WD_LAST   = 32'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  layer_q, layer_d;
    logic [31:0] wd_q, wd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        start_q, start_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] words_q, words_d;
    logic [7:0]  neurons_q, neurons_d;
    logic        rd_q, rd_d;
    logic [3:0]  addr_q, addr_d;
    logic        rd_dly_q, rd_dly_d;
    logic [3:0]  idx_dly_q, idx_dly_d;
    logic [3:0]  class_q, class_d;
    layer_cfg_t  cfg_s;
    logic [3:0]  best_idx_s;

    // Next-state and control decode
    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        wd_d      = wd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        start_d   = 1'b0;
        rd_d      = 1'b0;
        addr_d    = 4'd0;
        class_d   = class_q;
        rd_dly_d  = rd_q;
        idx_dly_d = addr_q;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (i_run) begin
                    state_d = ST_L_START;
                    layer_d = 2'd0;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    start_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_L_START: begin
                state_d = ST_L_WAIT;
                wd_d    = 32'd0;
            end
            ST_L_WAIT: begin
                if (i_layer_done) begin
                    if (layer_q < 2'd2) begin
                        layer_d = layer_q + 2'd1;
                        state_d = ST_L_START;
                        start_d = 1'b1;
                    end else begin
                        state_d = ST_AM_RD;
                        rd_d    = 1'b1;
                        addr_d  = 4'd0;
                    end
                end else if (WD_EN && (wd_q == WD_LAST)) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
            end
            ST_AM_RD: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_AM_DRAIN;
                end else begin
                    rd_d   = 1'b1;
                    addr_d = addr_q + 4'd1;
                end
            end
            ST_AM_DRAIN: begin
                state_d = ST_DONE;
                class_d = best_idx_s;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Layer configuration presented only while a layer is in flight
    always_comb begin
        case (layer_d)
            2'd0:    cfg_s = CFG_L1;
            2'd1:    cfg_s = CFG_L2;
            2'd2:    cfg_s = CFG_L3;
            default: cfg_s = '0;
        endcase
        if ((state_d == ST_L_START) || (state_d == ST_L_WAIT)) begin
            sel_d     = layer_d;
            words_d   = cfg_s.in_words;
            neurons_d = cfg_s.neurons;
        end else begin
            sel_d     = 2'd0;
            words_d   = 16'd0;
            neurons_d = 8'd0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            layer_q   <= 2'd0;
            wd_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            start_q   <= 1'b0;
            sel_q     <= 2'd0;
            words_q   <= 16'd0;
            neurons_q <= 8'd0;
            rd_q      <= 1'b0;
            addr_q    <= 4'd0;
            rd_dly_q  <= 1'b0;
            idx_dly_q <= 4'd0;
            class_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            layer_q   <= layer_d;
            wd_q      <= wd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            start_q   <= start_d;
            sel_q     <= sel_d;
            words_q   <= words_d;
            neurons_q <= neurons_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            rd_dly_q  <= rd_dly_d;
            idx_dly_q <= idx_dly_d;
            class_q   <= class_d;
        end
    end

    // Score data lands one cycle after its read, so the argmax follows a delayed strobe
    score_argmax #(
        .W  (SCORE_WIDTH),
        .IW (4)
    ) u_argmax (
        .clk      (clk),
        .rst_n    (reset),
        .start    (idx_dly_q == 4'd0),
        .valid    (rd_dly_q),
        .data     (i_score_data),
        .index    (idx_dly_q),
        .best_idx (best_idx_s),
        .best_val ()
    );

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_error       = error_q;
    assign o_layer_start = start_q;
    assign o_layer_sel   = sel_q;
    assign o_in_words    = words_q;
    assign o_neurons     = neurons_q;
    assign o_score_rd    = rd_q;
    assign o_score_addr  = addr_q;
    assign mnist_class   = class_q;

endmodule
